// File: rtl/exma_stage_reg_if.sv
// EX -> EX/MA pipeline register bundle: EX-stage ALU/control inputs, hazard controls,
// and the registered MA-side outputs. EXMA_PERF_COUNT_EN adds the performance counter outputs.
interface exma_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ValidIn;
  logic [WIDTH-1:0] ResultIn;
  logic             ZeroIn;
  logic             LessIn;
  logic [WIDTH-1:0] StoreDataIn;
  logic [4:0]       RdIn;
  logic             RegWriteIn;
  logic             MemReadIn;
  logic             MemWriteIn;
  logic [2:0]       BranchTypeIn;
  logic [WIDTH-1:0] BranchTargetIn;
  logic             StallIn;
  logic             FlushIn;

  logic             ValidOut;
  logic [WIDTH-1:0] ResultOut;
  logic [WIDTH-1:0] StoreDataOut;
  logic [4:0]       RdOut;
  logic             RegWriteOut;
  logic             MemReadOut;
  logic             MemWriteOut;
  logic             BranchTakenOut;
  logic [WIDTH-1:0] BranchTargetOut;
  logic             KillActiveOut;
`ifdef EXMA_PERF_COUNT_EN
  logic [31:0]      BranchCountOut;
  logic [31:0]      StallCountOut;
`endif

  // Driver side: EX stage and hazard unit, plus the MA-side consumer.
  modport master (
    output ValidIn, ResultIn, ZeroIn, LessIn, StoreDataIn, RdIn, RegWriteIn, MemReadIn,
           MemWriteIn, BranchTypeIn, BranchTargetIn, StallIn, FlushIn,
    input  ValidOut, ResultOut, StoreDataOut, RdOut, RegWriteOut, MemReadOut, MemWriteOut,
           BranchTakenOut, BranchTargetOut, KillActiveOut
`ifdef EXMA_PERF_COUNT_EN
    , input BranchCountOut, StallCountOut
`endif
  );

  // The pipeline register itself.
  modport slave (
    input  ValidIn, ResultIn, ZeroIn, LessIn, StoreDataIn, RdIn, RegWriteIn, MemReadIn,
           MemWriteIn, BranchTypeIn, BranchTargetIn, StallIn, FlushIn,
    output ValidOut, ResultOut, StoreDataOut, RdOut, RegWriteOut, MemReadOut, MemWriteOut,
           BranchTakenOut, BranchTargetOut, KillActiveOut
`ifdef EXMA_PERF_COUNT_EN
    , output BranchCountOut, StallCountOut
`endif
  );
endinterface

// File: rtl/exma_stage_reg.sv
// EX/MA pipeline register: captures ALU results, resolves branches into a one-cycle redirect
// pulse and squashes the branch shadow. EXMA_PERF_COUNT_EN adds branch/stall counters.
module exma_stage_reg #(
  parameter int unsigned KILL_SLOTS = 2,
  parameter int unsigned WIDTH      = 32
) (
  input logic             ClkIn,
  input logic             RstIn,
  exma_stage_reg_if.slave bus
);

  localparam logic [2:0] KillLoad = 3'(KILL_SLOTS);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic [4:0]       rd_q, rd_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic             memwrite_q, memwrite_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [2:0]       kill_q, kill_d;

  logic branch_cond;
  logic capture_taken;

  // LessIn is an unsigned compare, so blt/bge here are bltu/bgeu.
  always_comb begin
    branch_cond = 1'b0;
    case (bus.BranchTypeIn)
      3'b001:  branch_cond = bus.ZeroIn;
      3'b010:  branch_cond = !bus.ZeroIn;
      3'b011:  branch_cond = bus.LessIn;
      3'b100:  branch_cond = !bus.LessIn;
      3'b101:  branch_cond = 1'b1;
      default: branch_cond = 1'b0;
    endcase
  end

  assign capture_taken = !bus.FlushIn && !bus.StallIn && (kill_q == 3'd0) &&
                         bus.ValidIn && branch_cond;

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    store_d    = store_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    target_d   = target_q;
    kill_d     = kill_q;
    // The redirect is a pulse: it always drops on the next edge, even while stalled.
    taken_d    = 1'b0;

    if (bus.FlushIn || (!bus.StallIn && (kill_q != 3'd0 || !bus.ValidIn))) begin
      valid_d    = 1'b0;
      result_d   = '0;
      store_d    = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end

    if (bus.FlushIn) begin
      kill_d = 3'd0;
    end else if (bus.StallIn) begin
      kill_d = kill_q;
    end else if (kill_q != 3'd0) begin
      kill_d = kill_q - 3'd1;
    end else if (bus.ValidIn) begin
      valid_d    = 1'b1;
      result_d   = bus.ResultIn;
      store_d    = bus.StoreDataIn;
      rd_d       = bus.RdIn;
      regwrite_d = bus.RegWriteIn;
      memread_d  = bus.MemReadIn;
      memwrite_d = bus.MemWriteIn;
      if (capture_taken) begin
        taken_d  = 1'b1;
        target_d = bus.BranchTargetIn;
        kill_d   = KillLoad;
      end
    end
  end

  always_ff @(posedge ClkIn or posedge RstIn) begin
    if (RstIn) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      kill_q     <= 3'd0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
      kill_q     <= kill_d;
    end
  end

  assign bus.ValidOut        = valid_q;
  assign bus.ResultOut       = result_q;
  assign bus.StoreDataOut    = store_q;
  assign bus.RdOut           = rd_q;
  assign bus.RegWriteOut     = regwrite_q;
  assign bus.MemReadOut      = memread_q;
  assign bus.MemWriteOut     = memwrite_q;
  assign bus.BranchTakenOut  = taken_q;
  assign bus.BranchTargetOut = target_q;
  assign bus.KillActiveOut   = (kill_q != 3'd0);

`ifdef EXMA_PERF_COUNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge ClkIn or posedge RstIn) begin
    if (RstIn) begin
      branch_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (capture_taken) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (bus.StallIn && !bus.FlushIn) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.BranchCountOut = branch_cnt_q;
  assign bus.StallCountOut  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exma_stage_reg.sv
// Directed self-checking bench for exma_stage_reg (KILL_SLOTS=2, WIDTH=32).
module tb_exma_stage_reg;

  logic ClkIn;
  logic RstIn;
  int   n_checks;
  int   n_pass;

  exma_stage_reg_if #(.WIDTH(32)) bus ();

  exma_stage_reg #(
    .KILL_SLOTS(2),
    .WIDTH     (32)
  ) dut (
    .ClkIn(ClkIn),
    .RstIn(RstIn),
    .bus  (bus)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ClkIn);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic [2:0] bt,
                       input logic z, input logic l, input logic [31:0] tgt);
    bus.ValidIn        = v;
    bus.ResultIn       = res;
    bus.RdIn           = rd;
    bus.RegWriteIn     = rw;
    bus.MemReadIn      = 1'b0;
    bus.MemWriteIn     = mw;
    bus.StoreDataIn    = mw ? 32'hdead_beef : 32'h0;
    bus.BranchTypeIn   = bt;
    bus.ZeroIn         = z;
    bus.LessIn         = l;
    bus.BranchTargetIn = tgt;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    RstIn       = 1'b1;
    bus.StallIn = 1'b0;
    bus.FlushIn = 1'b0;
    drive(1'b1, 32'h1234, 5'd3, 1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 32'h99);
    step();
    step();
    check("rst_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("rst_result", bus.ResultOut, 32'h0);
    check("rst_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("rst_kill", {31'b0, bus.KillActiveOut}, 32'd0);
    RstIn = 1'b0;

    // Plain ALU op.
    drive(1'b1, 32'h10, 5'd5, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    step();
    check("alu_result", bus.ResultOut, 32'h10);
    check("alu_rd", {27'b0, bus.RdOut}, 32'd5);
    check("alu_regwrite", {31'b0, bus.RegWriteOut}, 32'd1);
    check("alu_valid", {31'b0, bus.ValidOut}, 32'd1);
    check("alu_taken", {31'b0, bus.BranchTakenOut}, 32'd0);

    // Invalid input gives a bubble and no branch.
    drive(1'b0, 32'h77, 5'd9, 1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 32'h60);
    step();
    check("bub_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("bub_result", bus.ResultOut, 32'h0);
    check("bub_taken", {31'b0, bus.BranchTakenOut}, 32'd0);

    // Taken beq, two shadow stores squashed, then an add passes.
    drive(1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 32'h40);
    step();
    check("beq_taken", {31'b0, bus.BranchTakenOut}, 32'd1);
    check("beq_target", bus.BranchTargetOut, 32'h40);
    check("beq_kill", {31'b0, bus.KillActiveOut}, 32'd1);
    drive(1'b1, 32'h100, 5'd0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
    step();
    check("st1_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("st1_memwrite", {31'b0, bus.MemWriteOut}, 32'd0);
    check("st1_pulse_off", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("st1_kill", {31'b0, bus.KillActiveOut}, 32'd1);
    drive(1'b1, 32'h104, 5'd0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
    step();
    check("st2_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("st2_memwrite", {31'b0, bus.MemWriteOut}, 32'd0);
    check("st2_kill", {31'b0, bus.KillActiveOut}, 32'd0);
    drive(1'b1, 32'h22, 5'd7, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    step();
    check("add_valid", {31'b0, bus.ValidOut}, 32'd1);
    check("add_result", bus.ResultOut, 32'h22);

    // Not-taken bne and blt.
    drive(1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h50);
    step();
    check("bne_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("bne_kill", {31'b0, bus.KillActiveOut}, 32'd0);
    drive(1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 32'h50);
    step();
    check("blt_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("blt_kill", {31'b0, bus.KillActiveOut}, 32'd0);

    // Taken jump, then a 3-cycle stall: pulse is single, state holds.
    drive(1'b1, 32'h55, 5'd1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 32'h80);
    step();
    check("jmp_taken", {31'b0, bus.BranchTakenOut}, 32'd1);
    check("jmp_target", bus.BranchTargetOut, 32'h80);
    bus.StallIn = 1'b1;
    drive(1'b1, 32'h200, 5'd2, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 32'hc0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
      check("stl_result", bus.ResultOut, 32'h55);
      check("stl_valid", {31'b0, bus.ValidOut}, 32'd1);
      check("stl_kill", {31'b0, bus.KillActiveOut}, 32'd1);
    end
    bus.StallIn = 1'b0;
    step();
    check("sq1_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("sq1_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("sq1_kill", {31'b0, bus.KillActiveOut}, 32'd1);
    step();
    check("sq2_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("sq2_kill", {31'b0, bus.KillActiveOut}, 32'd0);
    step();
    check("post_jmp_taken", {31'b0, bus.BranchTakenOut}, 32'd1);
    check("post_jmp_target", bus.BranchTargetOut, 32'hc0);

    // KillCnt now 2; one squash brings it to 1, then flush+stall together.
    drive(1'b1, 32'h300, 5'd4, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_fl_kill", {31'b0, bus.KillActiveOut}, 32'd1);
    bus.FlushIn = 1'b1;
    bus.StallIn = 1'b1;
    step();
    check("fl_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("fl_kill", {31'b0, bus.KillActiveOut}, 32'd0);
    check("fl_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("fl_regwrite", {31'b0, bus.RegWriteOut}, 32'd0);
    bus.FlushIn = 1'b0;
    bus.StallIn = 1'b0;
    step();
    check("after_fl_valid", {31'b0, bus.ValidOut}, 32'd1);
    check("after_fl_result", bus.ResultOut, 32'h300);

    // Asynchronous reset between edges, mid-squash.
    drive(1'b1, 32'h44, 5'd6, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 32'hf0);
    step();
    check("ar_pre_taken", {31'b0, bus.BranchTakenOut}, 32'd1);
    #2;
    RstIn = 1'b1;
    #1;
    check("ar_valid", {31'b0, bus.ValidOut}, 32'd0);
    check("ar_result", bus.ResultOut, 32'h0);
    check("ar_rd", {27'b0, bus.RdOut}, 32'd0);
    check("ar_taken", {31'b0, bus.BranchTakenOut}, 32'd0);
    check("ar_target", bus.BranchTargetOut, 32'h0);
    check("ar_kill", {31'b0, bus.KillActiveOut}, 32'd0);
    step();
    RstIn = 1'b0;
    drive(1'b1, 32'h66, 5'd8, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    step();
    check("ar_resume_valid", {31'b0, bus.ValidOut}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
